// File: rtl/rvfi_commit_sequencer.sv
// Serializes the per-cycle RVFI commit bundle into one in-order valid/ready stream
// and owns simulation exit detection (tohost store or cycle timeout).
package riscv;
  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 39;
endpackage

package rvfi_pkg;
  typedef struct packed {
    logic                     valid;
    logic [63:0]              order;
    logic [31:0]              insn;
    logic                     trap;
    logic [riscv::XLEN-1:0]   cause;
    logic [4:0]               rd_addr;
    logic [riscv::XLEN-1:0]   rd_wdata;
    logic [riscv::VLEN-1:0]   pc_rdata;
    logic [riscv::XLEN-1:0]   mem_addr;
    logic [riscv::XLEN/8-1:0] mem_wmask;
    logic [riscv::XLEN-1:0]   mem_wdata;
  } rvfi_instr_t;
endpackage

// state | meaning
// RUN   | capture live commits, stream them out, watch for tohost / timeout
// HALT  | exit reported; stream stopped, FIFO frozen, commits ignored until reset
module rvfi_commit_sequencer #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned DROP_W          = 16
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  input  logic [riscv::XLEN-1:0]                     tohost_addr_i,
  input  logic [31:0]                                timeout_i,
  output rvfi_pkg::rvfi_instr_t                      trace_o,
  output logic                                       trace_valid_o,
  input  logic                                       trace_ready_i,
  output logic [$clog2(DEPTH):0]                     level_o,
  output logic                                       overflow_o,
  output logic [DROP_W-1:0]                          drop_cnt_o,
  output logic                                       exit_valid_o,
  output logic                                       exit_timeout_o,
  output logic [riscv::XLEN-1:0]                     exit_code_o,
  output logic [63:0]                                exit_pc_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e                state_q, state_d;
  rvfi_pkg::rvfi_instr_t mem_q [DEPTH];
  rvfi_pkg::rvfi_instr_t head;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]         level, free_slots, n_acc, n_drop;
  logic [AW-1:0]         wr_idx [NR_COMMIT_PORTS];
  logic                  acc    [NR_COMMIT_PORTS];
  logic                  empty, pop, enq_en, tohost_hit, timeout_hit;
  logic [31:0]           cycle_q;
  logic [DROP_W-1:0]     drop_cnt_q;
  logic [DROP_W:0]       drop_sum;
  logic                  overflow_q, exit_timeout_q;
  logic [riscv::XLEN-1:0] exit_code_q;
  logic [63:0]           exit_pc_q;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign free_slots = DEPTH_P - level;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign enq_en     = (state_q == ST_RUN);
  assign pop        = trace_valid_o && trace_ready_i;

  // Room is judged on start-of-cycle occupancy, so a same-cycle pop never frees a slot.
  always_comb begin
    n_acc  = '0;
    n_drop = '0;
    for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
      acc[p]    = 1'b0;
      wr_idx[p] = wr_ptr_q[AW-1:0] + n_acc[AW-1:0];
      if (enq_en && (rvfi_i[p].valid || rvfi_i[p].trap)) begin
        if (n_acc < free_slots) begin
          acc[p] = 1'b1;
          n_acc  = n_acc + ONE;
        end else begin
          n_drop = n_drop + ONE;
        end
      end
    end
  end

  assign tohost_hit = pop && (tohost_addr_i != '0) && head.valid &&
                      (head.rd_addr == 5'd0) && (head.mem_wmask != '0) &&
                      (head.mem_addr == tohost_addr_i) && (head.mem_wdata != '0);
  assign timeout_hit = (state_q == ST_RUN) && (timeout_i != 32'd0) && (cycle_q > timeout_i);
  assign drop_sum    = {1'b0, drop_cnt_q} + (DROP_W+1)'(n_drop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (tohost_hit || timeout_hit) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
        if (acc[p]) mem_q[wr_idx[p]] <= rvfi_i[p];
      end
      wr_ptr_q <= wr_ptr_q + n_acc;
      if (pop) rd_ptr_q <= rd_ptr_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q        <= '0;
      drop_cnt_q     <= '0;
      overflow_q     <= 1'b0;
      exit_timeout_q <= 1'b0;
      exit_code_q    <= '0;
      exit_pc_q      <= '0;
    end else if (state_q == ST_RUN) begin
      if (cycle_q != '1) cycle_q <= cycle_q + 32'd1;
      if (n_drop != '0) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
      // tohost takes priority over a coincident timeout
      if (tohost_hit) begin
        exit_timeout_q <= 1'b0;
        exit_code_q    <= head.mem_wdata;
        exit_pc_q      <= {{(64-riscv::VLEN){head.pc_rdata[riscv::VLEN-1]}}, head.pc_rdata};
      end else if (timeout_hit) begin
        exit_timeout_q <= 1'b1;
        exit_code_q    <= '0;
        exit_pc_q      <= '0;
      end
    end
  end

  assign trace_o        = head;
  assign trace_valid_o  = !empty && (state_q == ST_RUN);
  assign level_o        = level;
  assign overflow_o     = overflow_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign exit_valid_o   = (state_q == ST_HALT);
  assign exit_timeout_o = exit_timeout_q;
  assign exit_code_o    = exit_code_q;
  assign exit_pc_o      = exit_pc_q;

endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Bench for rvfi_commit_sequencer: random and scenario stimulus against a queue-based
// reference model of the commit stream, drop accounting and exit detection.
module tb_rvfi_commit_sequencer;
  import rvfi_pkg::*;

  localparam int NP     = 2;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam logic [63:0] TOHOST = 64'h8000_1000;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  rvfi_instr_t [NP-1:0] rvfi_i;
  logic [63:0]          tohost_addr_i;
  logic [31:0]          timeout_i;
  rvfi_instr_t          trace_o;
  logic                 trace_valid_o;
  logic                 trace_ready_i;
  logic [4:0]           level_o;
  logic                 overflow_o;
  logic [DROP_W-1:0]    drop_cnt_o;
  logic                 exit_valid_o;
  logic                 exit_timeout_o;
  logic [63:0]          exit_code_o;
  logic [63:0]          exit_pc_o;

  rvfi_commit_sequencer #(.NR_COMMIT_PORTS(NP), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rvfi_i(rvfi_i), .tohost_addr_i(tohost_addr_i),
    .timeout_i(timeout_i), .trace_o(trace_o), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .level_o(level_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o), .exit_valid_o(exit_valid_o), .exit_timeout_o(exit_timeout_o),
    .exit_code_o(exit_code_o), .exit_pc_o(exit_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: the FIFO is just a queue of accepted commits
  rvfi_instr_t  m_q[$];
  bit           m_halt;
  int unsigned  m_cyc;
  int unsigned  m_drop;
  bit           m_ovf;
  bit           m_exit_to;
  logic [63:0]  m_code, m_pc;
  rvfi_instr_t  emitted[$];
  longint unsigned seq = 0;

  function automatic void model_step();
    bit          popped, th, to;
    rvfi_instr_t hd;
    int          room;
    if (rst_i) begin
      m_q.delete();
      m_halt = 0; m_cyc = 0; m_drop = 0; m_ovf = 0;
      m_exit_to = 0; m_code = '0; m_pc = '0;
      return;
    end
    if (m_halt) return;
    popped = (m_q.size() > 0) && trace_ready_i;
    hd     = (m_q.size() > 0) ? m_q[0] : '0;
    room   = DEPTH - m_q.size();
    th = popped && (tohost_addr_i != 0) && hd.valid && (hd.rd_addr == 0) &&
         (hd.mem_wmask != 0) && (hd.mem_addr == tohost_addr_i) && (hd.mem_wdata != 0);
    to = (timeout_i != 0) && (m_cyc > timeout_i);
    for (int p = 0; p < NP; p++) begin
      if (rvfi_i[p].valid || rvfi_i[p].trap) begin
        if (room > 0) begin
          m_q.push_back(rvfi_i[p]);
          room--;
        end else begin
          m_drop = (m_drop == 65535) ? 65535 : m_drop + 1;
          m_ovf  = 1;
        end
      end
    end
    if (popped) void'(m_q.pop_front());
    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (th) begin
      m_halt = 1; m_exit_to = 0; m_code = hd.mem_wdata;
      m_pc = 64'($signed(hd.pc_rdata));
    end else if (to) begin
      m_halt = 1; m_exit_to = 1; m_code = '0; m_pc = '0;
    end
  endfunction

  task automatic check_outputs();
    bit exp_v;
    exp_v = !m_halt && (m_q.size() > 0);
    check("trace_valid", 512'(trace_valid_o), 512'(exp_v));
    if (exp_v) check("trace_head", 512'(trace_o), 512'(m_q[0]));
    check("level", 512'(level_o), 512'(m_q.size()));
    check("overflow", 512'(overflow_o), 512'(m_ovf));
    check("drop_cnt", 512'(drop_cnt_o), 512'(m_drop));
    check("exit_valid", 512'(exit_valid_o), 512'(m_halt));
    check("exit_timeout", 512'(exit_timeout_o), 512'(m_exit_to));
    check("exit_code", 512'(exit_code_o), 512'(m_code));
    check("exit_pc", 512'(exit_pc_o), 512'(m_pc));
  endtask

  // inputs are set at the falling edge; step advances one clock and checks
  task automatic step();
    if (!rst_i && trace_valid_o && trace_ready_i) emitted.push_back(trace_o);
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    rvfi_i = '0;
    step();
    rst_i  = 1'b0;
  endtask

  function automatic rvfi_instr_t rand_entry(bit v, bit t, logic [63:0] pc);
    rvfi_instr_t e;
    e           = '0;
    e.valid     = v;
    e.trap      = t;
    e.order     = seq;
    seq++;
    e.insn      = $urandom;
    e.cause     = t ? 64'($urandom_range(0, 15)) : 64'd0;
    e.rd_addr   = 5'($urandom_range(1, 31));
    e.rd_wdata  = {$urandom, $urandom};
    e.pc_rdata  = pc[38:0];
    e.mem_addr  = {$urandom, $urandom};
    e.mem_wmask = 8'($urandom);
    e.mem_wdata = {$urandom, $urandom};
    return e;
  endfunction

  function automatic rvfi_instr_t store(logic [63:0] pc, logic [63:0] addr, logic [63:0] wdata);
    rvfi_instr_t e;
    e           = rand_entry(1'b1, 1'b0, pc);
    e.rd_addr   = 5'd0;
    e.mem_wmask = 8'hFF;
    e.mem_addr  = addr;
    e.mem_wdata = wdata;
    return e;
  endfunction

  task automatic random_session(input int cycles, input bit allow_exit);
    int ready_pct;
    int r;
    ready_pct = 70;
    for (int c = 0; c < cycles; c++) begin
      if (c % 40 == 0) ready_pct = $urandom_range(0, 100);
      trace_ready_i = ($urandom_range(0, 99) < ready_pct);
      for (int p = 0; p < NP; p++) begin
        r = $urandom_range(0, 19);
        if (r < 7)       rvfi_i[p] = '0;
        else if (r < 13) rvfi_i[p] = rand_entry(1'b1, 1'b0, 64'h8000_0000 + 64'(4 * c));
        else if (r < 15) rvfi_i[p] = rand_entry(1'b0, 1'b1, 64'h8000_0000 + 64'(4 * c));
        else if (r < 16) rvfi_i[p] = rand_entry(1'b1, 1'b1, 64'h8000_0000 + 64'(4 * c));
        else if (r < 18) rvfi_i[p] = store(64'h8000_0000 + 64'(4 * c), TOHOST, 64'd0);
        else if (r < 19 && allow_exit && c > cycles - 60)
          rvfi_i[p] = store(64'hFFFF_FFC0_0000_0100, TOHOST, 64'($urandom_range(1, 255)));
        else begin
          rvfi_i[p] = store(64'h8000_0000 + 64'(4 * c), TOHOST, 64'd5);
          rvfi_i[p].rd_addr = 5'($urandom_range(1, 31));
        end
      end
      step();
    end
    rvfi_i = '0;
  endtask

  initial begin
    int k;
    logic [63:0] first_ord;
    rst_i = 1'b1; trace_ready_i = 1'b0; rvfi_i = '0;
    tohost_addr_i = TOHOST; timeout_i = 32'd0;
    @(negedge clk_i);
    do_reset();
    check("rst_trace_o", 512'(trace_o), 512'(0));

    // 4 cycles of paired commits stream out in program order
    trace_ready_i = 1'b1;
    emitted.delete();
    for (int c = 0; c < 4; c++) begin
      rvfi_i[0] = rand_entry(1'b1, 1'b0, 64'h8000_0000 + 64'(8 * c));
      rvfi_i[1] = rand_entry(1'b1, 1'b0, 64'h8000_0004 + 64'(8 * c));
      step();
    end
    rvfi_i = '0;
    for (int c = 0; c < 8; c++) step();
    check("burst_count", 512'(emitted.size()), 512'(8));
    for (int i = 0; i < emitted.size(); i++)
      check("burst_pc", 512'(emitted[i].pc_rdata), 512'(64'h8000_0000 + 64'(4 * i)));

    // dead port 0, trapping port 1
    emitted.delete();
    rvfi_i[1] = rand_entry(1'b0, 1'b1, 64'h8000_0100);
    rvfi_i[1].cause = 64'd2;
    step();
    rvfi_i = '0;
    for (int c = 0; c < 3; c++) step();
    check("trap_count", 512'(emitted.size()), 512'(1));
    if (emitted.size() > 0) begin
      check("trap_flag", 512'(emitted[0].trap), 512'(1));
      check("trap_cause", 512'(emitted[0].cause), 512'(2));
    end
    check("trap_nodrop", 512'(drop_cnt_o), 512'(0));

    // fill while stalled: 18 live entries into 16 slots
    trace_ready_i = 1'b0;
    first_ord = seq;
    for (int c = 0; c < 9; c++) begin
      rvfi_i[0] = rand_entry(1'b1, 1'b0, 64'h8000_0200 + 64'(8 * c));
      rvfi_i[1] = rand_entry(1'b1, 1'b0, 64'h8000_0204 + 64'(8 * c));
      step();
    end
    rvfi_i = '0;
    check("fill_level", 512'(level_o), 512'(16));
    check("fill_drop", 512'(drop_cnt_o), 512'(2));
    check("fill_overflow", 512'(overflow_o), 512'(1));
    emitted.delete();
    trace_ready_i = 1'b1;
    for (int c = 0; c < 18; c++) step();
    check("drain_count", 512'(emitted.size()), 512'(16));
    for (int i = 0; i < emitted.size(); i++)
      check("drain_order", 512'(emitted[i].order), 512'(first_ord + 64'(i)));

    // tohost: wdata 0 is ignored, wdata 1 ends the run
    do_reset();
    trace_ready_i = 1'b1;
    rvfi_i[0] = store(64'h8000_0030, TOHOST, 64'd0);
    step();
    rvfi_i = '0;
    for (int c = 0; c < 3; c++) step();
    check("zero_store_noexit", 512'(exit_valid_o), 512'(0));
    emitted.delete();
    rvfi_i[0] = store(64'h8000_0040, TOHOST, 64'd1);
    rvfi_i[1] = rand_entry(1'b1, 1'b0, 64'h8000_0044);
    step();
    rvfi_i[0] = rand_entry(1'b1, 1'b0, 64'h8000_0048);
    rvfi_i[1] = rand_entry(1'b1, 1'b0, 64'h8000_004C);
    step();
    rvfi_i = '0;
    for (int c = 0; c < 5; c++) step();
    check("tohost_exit", 512'(exit_valid_o), 512'(1));
    check("tohost_code", 512'(exit_code_o), 512'(1));
    check("tohost_pc", 512'(exit_pc_o), 512'(64'h8000_0040));
    check("tohost_emitted", 512'(emitted.size()), 512'(1));

    // reset while halted with 5 entries frozen in the FIFO
    do_reset();
    trace_ready_i = 1'b0;
    rvfi_i[0] = store(64'h8000_0080, TOHOST, 64'h2a);
    rvfi_i[1] = rand_entry(1'b1, 1'b0, 64'h8000_0084);
    step();
    for (int c = 0; c < 2; c++) begin
      rvfi_i[0] = rand_entry(1'b1, 1'b0, 64'h8000_0088 + 64'(8 * c));
      rvfi_i[1] = rand_entry(1'b0, 1'b1, 64'h8000_008C + 64'(8 * c));
      step();
    end
    rvfi_i = '0;
    trace_ready_i = 1'b1;
    step();
    check("halt_level", 512'(level_o), 512'(5));
    check("halt_exit", 512'(exit_valid_o), 512'(1));
    do_reset();
    check("rst2_level", 512'(level_o), 512'(0));
    check("rst2_trace_o", 512'(trace_o), 512'(0));
    emitted.delete();
    rvfi_i[0] = rand_entry(1'b1, 1'b0, 64'h8000_0400);
    rvfi_i[1] = rand_entry(1'b1, 1'b0, 64'h8000_0404);
    step();
    rvfi_i = '0;
    for (int c = 0; c < 3; c++) step();
    check("rst2_flow", 512'(emitted.size()), 512'(2));

    // timeout 100: exit becomes visible 102 edges after reset release
    do_reset();
    timeout_i = 32'd100;
    k = 0;
    while (!exit_valid_o && k < 200) begin
      step();
      k++;
    end
    check("timeout_cycle", 512'(k), 512'(102));
    check("timeout_flag", 512'(exit_timeout_o), 512'(1));

    do_reset();
    timeout_i = 32'd0;
    for (int c = 0; c < 300; c++) step();
    check("no_timeout", 512'(exit_valid_o), 512'(0));

    // randomized sessions
    do_reset();
    random_session(400, 1'b0);
    do_reset();
    timeout_i = 32'($urandom_range(150, 400));
    random_session(300, 1'b1);
    do_reset();
    timeout_i = 32'd0;
    random_session(300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
